// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing an 8-bit register pointer with auto-increment writes (and reads when I2C_TARGET_READ_EN is defined)
// Ports: clk, reset (sync, active-high); i2c_scl/i2c_sda_in async pad inputs; i2c_sda_oe open-drain pull-low;
//   reg_addr register pointer; wr_valid/wr_data one-clk write strobe; rd_data contents of reg_addr; busy START..STOP.
// Macro I2C_TARGET_READ_EN: enables R/W=1 transfers; otherwise read addressing is NACKed and rd_data is unused.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h60,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic [7:0] reg_addr,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       busy
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_t;
  state_t state;
  // index 0 = SCL, index 1 = SDA
  logic [1:0] s1, s2, f, q;
  logic [1:0][CW-1:0] c;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic scl_rise, scl_fall, start, stop, addr_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
      f <= 2'b11;
      q <= 2'b11;
      c <= '0;
    end else begin
      s1 <= {i2c_sda_in, i2c_scl};
      s2 <= s1;
      q <= f;
      for (int i = 0; i < 2; i++) begin
        c[i] <= (s2[i] == f[i] || c[i] == CW'(FILTER_LEN - 1)) ? '0 : c[i] + CW'(1);
        if (s2[i] != f[i] && c[i] == CW'(FILTER_LEN - 1)) f[i] <= s2[i];
      end
    end
  end
  assign scl_rise = f[0] & ~q[0];
  assign scl_fall = ~f[0] & q[0];
  assign start = f[0] & q[0] & q[1] & ~f[1];
  assign stop = f[0] & q[0] & ~q[1] & f[1];
  // general call (address 0) is never acknowledged
`ifdef I2C_TARGET_READ_EN
  logic rw, nack;
  assign addr_ok = shift[7:1] == TARGET_ADDR && shift[7:1] != 7'd0;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign addr_ok = shift[7:1] == TARGET_ADDR && shift[7:1] != 7'd0 && !shift[0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      i2c_sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_valid <= 1'b0;
      wr_data <= '0;
      reg_addr <= '0;
`ifdef I2C_TARGET_READ_EN
      rw <= 1'b0;
      nack <= 1'b0;
`endif
    end else begin
      wr_valid <= 1'b0;
      if (start) begin
        state <= ADDR;
        bit_cnt <= '0;
        i2c_sda_oe <= 1'b0;
        busy <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        i2c_sda_oe <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift <= {shift[6:0], f[1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                state <= addr_ok ? ADDR_ACK : IDLE;
                i2c_sda_oe <= addr_ok;
`ifdef I2C_TARGET_READ_EN
                rw <= shift[0];
`endif
              end else if (state == PTR) begin
                state <= PTR_ACK;
                reg_addr <= shift;
                i2c_sda_oe <= 1'b1;
              end else begin
                state <= WDATA_ACK;
                wr_valid <= 1'b1;
                wr_data <= shift;
                i2c_sda_oe <= 1'b1;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            state <= PTR;
            i2c_sda_oe <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            // first read bit goes out on the same fall that ends the address ACK
            if (rw) begin
              state <= RDATA;
              shift <= rd_data;
              i2c_sda_oe <= ~rd_data[7];
              bit_cnt <= 4'd1;
            end
`endif
          end
          PTR_ACK: if (scl_fall) begin
            state <= WDATA;
            i2c_sda_oe <= 1'b0;
          end
          WDATA_ACK: if (scl_fall) begin
            state <= WDATA;
            i2c_sda_oe <= 1'b0;
            reg_addr <= reg_addr + 8'd1;
          end
`ifdef I2C_TARGET_READ_EN
          // bit_cnt counts bits already placed on the bus
          RDATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state <= RDATA_ACK;
              i2c_sda_oe <= 1'b0;
            end else begin
              shift <= {shift[6:0], 1'b0};
              i2c_sda_oe <= ~shift[6];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RDATA_ACK: if (scl_rise) begin
            nack <= f[1];
            reg_addr <= reg_addr + 8'd1;
          end else if (scl_fall) begin
            if (nack) state <= IDLE;
            else begin
              state <= RDATA;
              shift <= rd_data;
              i2c_sda_oe <= ~rd_data[7];
              bit_cnt <= 4'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-master stimulus with a write scoreboard for i2c_target_regs
module tb_i2c_target_regs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic oe, wr_valid, busy;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic sda_line;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic oe_seen = 1'b0;
  bit glitch = 1'b0;
  assign sda_line = sda_m & ~oe;
  assign rd_data = reg_addr ^ 8'h5A;
  always #5 clk = ~clk;
  i2c_target_regs dut (
    .clk(clk), .reset(reset), .i2c_scl(scl_m), .i2c_sda_in(sda_line), .i2c_sda_oe(oe),
    .reg_addr(reg_addr), .wr_valid(wr_valid), .wr_data(wr_data), .rd_data(rd_data), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", reg_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {reg_addr, wr_data}, {16'h0, mon_e});
      end
    end
  always @(posedge clk) if (oe) oe_seen = 1'b1;
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write_bit(input logic b);
    sda_m = b;
    if (glitch) begin
      clks(2); scl_m = 1'b1; clks(1); scl_m = 1'b0; clks(3); scl_m = 1'b1; clks(2); scl_m = 1'b0; clks(2);
    end else clks(10);
    scl_m = 1'b1;
    if (glitch) begin
      clks(8); sda_m = ~b; clks(1); sda_m = b; clks(4); sda_m = ~b; clks(2); sda_m = b; clks(5);
    end else clks(20);
    scl_m = 1'b0;
    clks(10);
  endtask
  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    clks(10);
    scl_m = 1'b1;
    clks(10);
    b = sda_line;
    clks(10);
    scl_m = 1'b0;
    clks(10);
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask
  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask
  task automatic start_c();
    sda_m = 1'b1; clks(10); scl_m = 1'b1; clks(10); sda_m = 1'b0; clks(10); scl_m = 1'b0; clks(10);
  endtask
  task automatic stop_c();
    sda_m = 1'b0; clks(10); scl_m = 1'b1; clks(10); sda_m = 1'b1; clks(10);
  endtask
  initial begin
    logic a;
    logic [7:0] d;
    clks(4);
    reset = 1'b0;
    clks(2);
    chk("reset_oe", oe, 0);
    chk("reset_wr_valid", wr_valid, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_reg_addr", reg_addr, 0);
    chk("reset_busy", busy, 0);
    clks(10);
    // plain write of two bytes
    start_c();
    chk("t1_busy", busy, 1);
    send_byte(8'hC0, a); chk("t1_addr_ack", a, 0);
    send_byte(8'h10, a); chk("t1_ptr_ack", a, 0);
    chk("t1_ptr", reg_addr, 8'h10);
    exp_q.push_back(16'h10A5);
    send_byte(8'hA5, a); chk("t1_d0_ack", a, 0);
    exp_q.push_back(16'h113C);
    send_byte(8'h3C, a); chk("t1_d1_ack", a, 0);
    chk("t1_reg_addr", reg_addr, 8'h12);
    stop_c(); clks(10);
    chk("t1_busy_stop", busy, 0);
    chk("t1_queue", exp_q.size(), 0);
    // wrong address is ignored
    oe_seen = 1'b0;
    start_c();
    send_byte(8'hC2, a); chk("t2_addr_nack", a, 1);
    send_byte(8'h10, a); chk("t2_b1_nack", a, 1);
    send_byte(8'h55, a); chk("t2_b2_nack", a, 1);
    stop_c(); clks(10);
    chk("t2_oe_never", oe_seen, 0);
    chk("t2_reg_addr", reg_addr, 8'h12);
    // glitches shorter than the filter
    glitch = 1'b1;
    start_c();
    send_byte(8'hC0, a); chk("t4_addr_ack", a, 0);
    send_byte(8'h20, a); chk("t4_ptr_ack", a, 0);
    exp_q.push_back(16'h2077);
    send_byte(8'h77, a); chk("t4_d_ack", a, 0);
    glitch = 1'b0;
    stop_c(); clks(10);
    chk("t4_reg_addr", reg_addr, 8'h21);
    chk("t4_queue", exp_q.size(), 0);
    // STOP mid-byte discards the partial byte
    start_c();
    send_byte(8'hC0, a); chk("t5_addr_ack", a, 0);
    send_byte(8'h30, a); chk("t5_ptr_ack", a, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    stop_c(); clks(10);
    chk("t5_busy", busy, 0);
    chk("t5_reg_addr", reg_addr, 8'h30);
    // reset while driving ACK releases the bus on the next clock
    start_c();
    d = 8'hC0;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    sda_m = 1'b1;
    chk("t5_ack_drive", oe, 1);
    reset = 1'b1;
    clks(1);
    chk("t5_reset_oe", oe, 0);
    chk("t5_reset_busy", busy, 0);
    chk("t5_reset_reg_addr", reg_addr, 0);
    reset = 1'b0;
    stop_c(); clks(10);
`ifdef I2C_TARGET_READ_EN
    start_c();
    send_byte(8'hC0, a); chk("t3_addr_ack", a, 0);
    send_byte(8'hFF, a); chk("t3_ptr_ack", a, 0);
    chk("t3_ptr", reg_addr, 8'hFF);
    start_c();
    send_byte(8'hC1, a); chk("t3_raddr_ack", a, 0);
    recv_byte(d, 1'b0); chk("t3_rd0", d, 8'hA5);
    recv_byte(d, 1'b1); chk("t3_rd1", d, 8'h5A);
    stop_c(); clks(10);
    chk("t3_reg_addr_wrap", reg_addr, 8'h01);
    chk("t3_busy", busy, 0);
`else
    oe_seen = 1'b0;
    start_c();
    send_byte(8'hC1, a); chk("t6_read_nack", a, 1);
    stop_c(); clks(10);
    chk("t6_oe_never", oe_seen, 0);
    start_c();
    send_byte(8'hC0, a); chk("t6_addr_ack", a, 0);
    send_byte(8'h40, a); chk("t6_ptr_ack", a, 0);
    exp_q.push_back(16'h4099);
    send_byte(8'h99, a); chk("t6_d_ack", a, 0);
    stop_c(); clks(10);
    chk("t6_reg_addr", reg_addr, 8'h41);
`endif
    clks(5);
    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
